// File: rtl/tx_fifo_bridge_pkg.sv
// -----------------------------------------------------------------------------
// tx_fifo_bridge_pkg
// Shared definitions for the sequencer-to-UART transmit bridge:
//   - SEQ_DW            : sequencer datapath width (bridge data width binds here)
//   - TX_ACK_TO_DEFAULT : default cycles to wait for the UART to go busy
//   - tx_state_e        : launch FSM state encoding
//   - cnt_width()       : width of a counter that must hold 0..max_val
// -----------------------------------------------------------------------------
package tx_fifo_bridge_pkg;

    localparam int SEQ_DW            = 8;
    localparam int TX_ACK_TO_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

    // Bits needed to represent every value from 0 to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/tx_fifo_bridge_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Register-array circular buffer. Pointers carry one extra MSB so that
// equal low bits with different MSBs means full, identical pointers means
// empty; pointers wrap modulo 2*DEPTH.
// A write while full is accepted only if a pop happens in the same cycle
// (the slot being vacated is the one written). Otherwise it is ignored.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_srst     : synchronous clear (held while the reset synchroniser drains)
//   i_wr       : write request, i_wdata data to store
//   i_pop      : pop request (ignored when empty)
//   o_rdata    : head entry (valid when not empty)
//   o_full     : level == DEPTH
//   o_empty    : level == 0
//   o_level    : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
    import tx_fifo_bridge_pkg::*;
#(
    parameter  int DW    = SEQ_DW,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_srst,
    input  logic          i_wr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_wr_en;
    logic          w_rd_en;

    // Modular pointer difference is the occupancy thanks to the extra MSB.
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_level == LVL_FULL);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_wr && (!o_full || w_rd_en);

    // Pointer update: advance on accepted write / pop, cleared by either reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/tx_fifo_bridge.sv
// -----------------------------------------------------------------------------
// tx_fifo_bridge
// Buffers bytes from the sequencer and launches them one at a time into a
// UART transmitter using a one-cycle strobe, then waits for the UART to go
// busy and idle again (or for a timeout if it never acknowledges).
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-high reset (release synchronised)
//   i_data      : byte from the sequencer
//   i_valid     : one-cycle write strobe
//   o_busy      : FIFO full, back-pressure to the sequencer
//   o_tx_data   : byte presented to the UART, held until the next pop
//   o_tx_stb    : one-cycle launch strobe
//   i_tx_busy   : UART transmitter busy
//   o_level     : FIFO occupancy
//   o_drop_cnt  : writes lost to overflow, saturating at 255
// -----------------------------------------------------------------------------
module tx_fifo_bridge
    import tx_fifo_bridge_pkg::*;
#(
    parameter  int DW     = SEQ_DW,
    parameter  int DEPTH  = 8,
    parameter  int ACK_TO = TX_ACK_TO_DEFAULT,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_busy,
    output logic [DW-1:0] o_tx_data,
    output logic          o_tx_stb,
    input  logic          i_tx_busy,
    output logic [AW:0]   o_level,
    output logic [7:0]    o_drop_cnt
);

    localparam int            CW       = cnt_width(ACK_TO);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TO - 1);

    logic [1:0]    r_rst_sync;
    logic          w_srst;
    tx_state_e     r_state;
    tx_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_tx_data;
    logic          r_tx_stb;
    logic [7:0]    r_drop_cnt;
    logic          w_pop;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    logic [DW-1:0] w_head;

    // Reset release synchroniser: set asynchronously, drains to zero over two edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_srst = r_rst_sync[1];

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_srst  (w_srst),
        .i_wr    (i_valid),
        .i_wdata (i_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    // A full FIFO loses the write unless the launcher frees a slot this cycle.
    assign w_drop = i_valid && w_full && !w_pop;

    // Launch FSM next-state and control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !i_tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_LAUNCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (i_tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else begin
                    // No acknowledge: give up after ACK_TO cycles, byte treated as sent.
                    w_cnt_inc = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (w_srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Acknowledge timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_srst || w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Output byte register: captures the head on pop and holds it until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_data <= '0;
        end else if (w_srst) begin
            r_tx_data <= '0;
        end else if (w_pop) begin
            r_tx_data <= w_head;
        end
    end

    // Launch strobe: high for the single cycle spent in LAUNCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_stb <= 1'b0;
        end else if (w_srst) begin
            r_tx_stb <= 1'b0;
        end else begin
            r_tx_stb <= w_pop;
        end
    end

    // Overflow drop counter, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= 8'd0;
        end else if (w_srst) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_busy     = w_full;
    assign o_tx_data  = r_tx_data;
    assign o_tx_stb   = r_tx_stb;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_tx_fifo_bridge.sv
module tb_tx_fifo_bridge;

    localparam int DEPTH  = 8;
    localparam int ACK_TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_busy;
    logic [7:0] o_tx_data;
    logic       o_tx_stb;
    logic       i_tx_busy;
    logic [3:0] o_level;
    logic [7:0] o_drop_cnt;

    logic       man_busy = 1'b0;
    logic       slow_uart = 1'b0;
    int         busy_left = 0;
    int         cyc = 0;

    int checks = 0;
    int failures = 0;

    logic [7:0] stb_data[$];
    int         stb_edge[$];
    logic [7:0] exp_q[$];
    int         stb_viol = 0;
    int         busy_seen = 0;

    tx_fifo_bridge #(.DW(8), .DEPTH(DEPTH), .ACK_TO(ACK_TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_busy     (o_busy),
        .o_tx_data  (o_tx_data),
        .o_tx_stb   (o_tx_stb),
        .i_tx_busy  (i_tx_busy),
        .o_level    (o_level),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slow UART: busy rises the cycle after a strobe and stays high 20 cycles.
    always @(posedge clk) begin
        if (rst) busy_left <= 0;
        else if (slow_uart && o_tx_stb) busy_left <= 20;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end

    assign i_tx_busy = man_busy | (busy_left > 0);

    // Strobe monitor; records the edge at which the UART samples the strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_tx_stb) begin
                stb_data.push_back(o_tx_data);
                stb_edge.push_back(cyc + 1);
                if (i_tx_busy) stb_viol++;
            end
            if (o_busy) busy_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        i_data  = d;
        i_valid = 1'b1;
        step(1);
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_valid   = 1'b0;
        man_busy  = 1'b0;
        slow_uart = 1'b0;
        rst       = 1'b1;
        step(2);
        check("rst_stb",   o_tx_stb,   0);
        check("rst_data",  o_tx_data,  0);
        check("rst_busy",  o_busy,     0);
        check("rst_level", o_level,    0);
        check("rst_drop",  o_drop_cnt, 0);
        rst = 1'b0;
        step(4);
        stb_data.delete();
        stb_edge.delete();
        exp_q.delete();
        busy_seen = 0;
    endtask

    // Wait (bounded) for every expected byte, let the bridge settle, then compare.
    task automatic drain_check(input string tag);
        int budget;
        budget = 400;
        while (stb_data.size() < exp_q.size() && budget > 0) begin
            step(1);
            budget--;
        end
        step(30);
        check({tag, "_count"}, stb_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < stb_data.size(); i++)
            check({tag, "_byte"}, stb_data[i], exp_q[i]);
        check({tag, "_level"}, o_level, 0);
    endtask

    initial begin
        int wcyc;
        int n;
        int lvl;
        int model_drop;
        int nstb;
        logic [7:0] d;

        rst = 1'b1;

        // Single byte, UART idle
        do_reset();
        write_byte(8'h41);
        wcyc = cyc;
        check("single_level_w", o_level, 1);
        step(1);
        check("single_stb", o_tx_stb, 1);
        check("single_data", o_tx_data, 8'h41);
        check("single_level_pop", o_level, 0);
        step(1);
        check("single_stb_once", o_tx_stb, 0);
        step(10);
        check("single_count", stb_data.size(), 1);
        if (stb_edge.size() > 0) check("single_latency", stb_edge[0], wcyc + 2);
        check("single_hold", o_tx_data, 8'h41);

        // Burst into a slow UART
        do_reset();
        slow_uart = 1'b1;
        for (int k = 0; k < 8; k++) begin
            write_byte(8'h30 + 8'(k));
            exp_q.push_back(8'h30 + 8'(k));
        end
        drain_check("burst");
        check("burst_no_busy", busy_seen, 0);
        for (int i = 1; i < stb_edge.size(); i++)
            check("burst_gap_ge22", (stb_edge[i] - stb_edge[i-1]) >= 22, 1);
        slow_uart = 1'b0;

        // Overflow with UART held busy
        do_reset();
        man_busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            write_byte(8'h60 + 8'(k));
            if (k == 6) check("ovf_busy_7", o_busy, 0);
            if (k == 7) check("ovf_busy_8", o_busy, 1);
            if (k < 8) exp_q.push_back(8'h60 + 8'(k));
        end
        check("ovf_drop", o_drop_cnt, 2);
        check("ovf_level", o_level, 8);
        check("ovf_busy", o_busy, 1);
        man_busy = 1'b0;
        drain_check("ovf");

        // Full FIFO with write and pop in the same cycle
        do_reset();
        man_busy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            write_byte(8'h70 + 8'(k));
            exp_q.push_back(8'h70 + 8'(k));
        end
        check("fullpop_pre_level", o_level, 8);
        i_data   = 8'h55;
        i_valid  = 1'b1;
        man_busy = 1'b0;
        step(1);
        i_valid = 1'b0;
        exp_q.push_back(8'h55);
        check("fullpop_level", o_level, 8);
        check("fullpop_drop", o_drop_cnt, 0);
        check("fullpop_stb", o_tx_stb, 1);
        check("fullpop_data", o_tx_data, 8'h70);
        drain_check("fullpop");

        // Acknowledge timeout, UART never busy
        do_reset();
        write_byte(8'hA5);
        wcyc = cyc;
        write_byte(8'h5A);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        drain_check("ackto");
        if (stb_edge.size() > 1) begin
            check("ackto_first", stb_edge[0], wcyc + 2);
            check("ackto_spacing", stb_edge[1] - stb_edge[0], ACK_TO + 2);
        end

        // Reset while waiting for the UART to finish, 3 bytes queued
        do_reset();
        slow_uart = 1'b1;
        for (int k = 0; k < 4; k++) write_byte(8'h81 + 8'(k));
        step(2);
        check("midrst_level_pre", o_level, 3);
        check("midrst_stb_pre", stb_data.size(), 1);
        nstb = stb_data.size();
        rst = 1'b1;
        #1;
        check("midrst_stb", o_tx_stb, 0);
        check("midrst_data", o_tx_data, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_level", o_level, 0);
        step(2);
        rst = 1'b0;
        step(12);
        check("midrst_no_stb", stb_data.size(), nstb);
        check("midrst_level_post", o_level, 0);
        slow_uart = 1'b0;

        // Drop counter saturation
        do_reset();
        man_busy = 1'b1;
        for (int k = 0; k < 270; k++) begin
            write_byte(8'(k));
            if (k < 8) exp_q.push_back(8'(k));
        end
        check("sat_drop", o_drop_cnt, 255);
        check("sat_level", o_level, 8);
        man_busy = 1'b0;
        drain_check("sat");

        // Randomised bursts against a queue model
        do_reset();
        model_drop = 0;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(3, 12);
            lvl = 0;
            exp_q.delete();
            stb_data.delete();
            stb_edge.delete();
            man_busy = 1'b1;
            step(1);
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                if (lvl < DEPTH) begin
                    exp_q.push_back(d);
                    lvl++;
                end else if (model_drop < 255) begin
                    model_drop++;
                end
                write_byte(d);
                step($urandom_range(0, 2));
            end
            check("rand_level", o_level, lvl);
            check("rand_busy", o_busy, lvl == DEPTH);
            check("rand_drop", o_drop_cnt, model_drop);
            slow_uart = 1'($urandom_range(0, 1));
            man_busy = 1'b0;
            drain_check("rand");
            slow_uart = 1'b0;
        end

        check("stb_while_busy", stb_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
